// File: rtl/reg_file_cc_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_cc_pkg
// Shared constants and types for the register file / condition-code block.
//   DATA_W      : default register and bus width
//   NREGS       : default number of general registers
//   REG_ADDR_W  : width of a register address field in the instruction
//   R7_IDX      : index of R7, the DRMUX=1 destination
//   NZP_RESET   : condition-code value after reset ({N,Z,P} = 010)
//   nzp_bit_e   : bit positions of N, Z and P inside the NZP vector
// -----------------------------------------------------------------------------
package reg_file_cc_pkg;

    localparam int DATA_W     = 16;
    localparam int NREGS      = 8;
    localparam int REG_ADDR_W = 3;

    localparam logic [REG_ADDR_W-1:0] R7_IDX    = 3'd7;
    localparam logic [2:0]            NZP_RESET = 3'b010;

    typedef enum logic [1:0] {
        NZP_P = 2'd0,
        NZP_Z = 2'd1,
        NZP_N = 2'd2
    } nzp_bit_e;

endpackage : reg_file_cc_pkg

// File: rtl/reg_file_cc_nzp_ben.sv
// -----------------------------------------------------------------------------
// nzp_ben
// Condition-code register and latched branch-enable.
// Ports:
//   clk      in   clock, state updates on rising edge
//   reset    in   synchronous, active-high; NZP -> 010, BEN -> 0
//   bus      in   write-back data the condition codes are derived from
//   br_mask  in   IR[11:9], branch mask {n,z,p}
//   ld_cc    in   load NZP from bus
//   ld_ben   in   latch BEN from the current (pre-edge) NZP and br_mask
//   nzp      out  condition codes {N,Z,P}
//   ben      out  latched branch enable
// -----------------------------------------------------------------------------
module nzp_ben #(
    parameter int DATA_W = reg_file_cc_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] bus,
    input  logic [2:0]        br_mask,
    input  logic              ld_cc,
    input  logic              ld_ben,
    output logic [2:0]        nzp,
    output logic              ben
);
    import reg_file_cc_pkg::*;

    logic [2:0] nzp_d, nzp_q;
    logic       ben_d, ben_q;

    always_comb begin
        nzp_d = nzp_q;
        ben_d = ben_q;

        // Exactly one code bit is set after a load: sign bit wins, then zero.
        if (ld_cc) begin
            nzp_d = '0;
            if (bus[DATA_W-1])
                nzp_d[NZP_N] = 1'b1;
            else if (bus == '0)
                nzp_d[NZP_Z] = 1'b1;
            else
                nzp_d[NZP_P] = 1'b1;
        end

        // Uses nzp_q, so a simultaneous ld_cc does not affect this decision.
        if (ld_ben)
            ben_d = (br_mask[2] & nzp_q[NZP_N]) |
                    (br_mask[1] & nzp_q[NZP_Z]) |
                    (br_mask[0] & nzp_q[NZP_P]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nzp_q <= NZP_RESET;
            ben_q <= 1'b0;
        end else begin
            nzp_q <= nzp_d;
            ben_q <= ben_d;
        end
    end

    assign nzp = nzp_q;
    assign ben = ben_q;

endmodule : nzp_ben

// File: rtl/reg_file_cc.sv
// -----------------------------------------------------------------------------
// reg_file_cc
// General register file (NREGS x DATA_W) with two combinational read ports,
// plus condition codes and branch enable (nzp_ben sub-module).
// Ports:
//   Clk     in   clock, all state updates on rising edge
//   Reset   in   synchronous, active-high; registers -> 0, NZP -> 010, BEN -> 0
//   Bus     in   write-back data
//   IR      in   instruction: DR/SR1 at [11:9], SR1 alt at [8:6], SR2 at [2:0]
//   LD_REG  in   write Bus into R[DR]
//   LD_CC   in   load NZP from Bus
//   LD_BEN  in   latch branch enable
//   DRMUX   in   0: DR = IR[11:9], 1: DR = R7
//   SR1MUX  in   0: SR1 = IR[11:9], 1: SR1 = IR[8:6]
//   SR1Out  out  R[SR1]
//   SR2Out  out  R[IR[2:0]]
//   NZP     out  condition codes {N,Z,P}
//   BEN     out  latched branch enable
// Configuration:
//   REGFILE_BYPASS_EN  when defined, a read port whose address matches DR
//                      during a write returns Bus in the same cycle (not
//                      while Reset is high).
// -----------------------------------------------------------------------------
module reg_file_cc #(
    parameter int DATA_W = reg_file_cc_pkg::DATA_W,
    parameter int NREGS  = reg_file_cc_pkg::NREGS
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Bus,
    input  logic [15:0]       IR,
    input  logic              LD_REG,
    input  logic              LD_CC,
    input  logic              LD_BEN,
    input  logic              DRMUX,
    input  logic              SR1MUX,
    output logic [DATA_W-1:0] SR1Out,
    output logic [DATA_W-1:0] SR2Out,
    output logic [2:0]        NZP,
    output logic              BEN
);
    import reg_file_cc_pkg::*;

    logic [REG_ADDR_W-1:0] dr_addr;
    logic [REG_ADDR_W-1:0] sr1_addr;
    logic [REG_ADDR_W-1:0] sr2_addr;

    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] regs_q [NREGS];

    // Opcode and immediate bits are decoded elsewhere in the datapath.
    logic unused_ir;
    assign unused_ir = ^{IR[15:12], IR[5:3]};

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    always_comb begin
        dr_addr  = DRMUX  ? R7_IDX   : IR[11:9];
        sr1_addr = SR1MUX ? IR[8:6]  : IR[11:9];
        sr2_addr = IR[2:0];
    end

    // -------------------------------------------------------------------------
    // Register array
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a full default first; a path that
        // leaves a variable unassigned would infer a latch.
        regs_d = regs_q;
        if (LD_REG)
            regs_d[dr_addr] = Bus;
    end

    always_ff @(posedge Clk) begin
        // NOTE: this array is small and must be architecturally zero after
        // reset, so it lives in flops with a reset; a RAM macro would not.
        if (Reset) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge
            // values; blocking here would create order-dependent races.
            regs_q <= regs_d;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports (zero-latency)
    // -------------------------------------------------------------------------
    always_comb begin
        SR1Out = regs_q[sr1_addr];
        SR2Out = regs_q[sr2_addr];
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight write; suppressed during reset because the
        // write itself is discarded.
        if (LD_REG && !Reset) begin
            if (sr1_addr == dr_addr)
                SR1Out = Bus;
            if (sr2_addr == dr_addr)
                SR2Out = Bus;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Condition codes and branch enable
    // -------------------------------------------------------------------------
    nzp_ben #(
        .DATA_W (DATA_W)
    ) u_nzp_ben (
        .clk     (Clk),
        .reset   (Reset),
        .bus     (Bus),
        .br_mask (IR[11:9]),
        .ld_cc   (LD_CC),
        .ld_ben  (LD_BEN),
        .nzp     (NZP),
        .ben     (BEN)
    );

endmodule : reg_file_cc

// File: tb/tb_reg_file_cc.sv
// -----------------------------------------------------------------------------
// tb_reg_file_cc
// Self-checking bench for reg_file_cc. A reference model predicts read-port
// values (before the edge) and NZP/BEN (after the edge); predictions are
// queued at drive time and popped when the DUT output is sampled.
// Build with +define+REGFILE_BYPASS_EN to check the bypass variant.
// -----------------------------------------------------------------------------
module tb_reg_file_cc;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_reg, ld_cc, ld_ben, drmux, sr1mux;
    logic [15:0] ir, bus;
    logic [15:0] sr1_out, sr2_out;
    logic [2:0]  nzp;
    logic        ben;

    always #5 clk = ~clk;

    reg_file_cc #(
        .DATA_W (16),
        .NREGS  (8)
    ) dut (
        .Clk    (clk),
        .Reset  (rst),
        .Bus    (bus),
        .IR     (ir),
        .LD_REG (ld_reg),
        .LD_CC  (ld_cc),
        .LD_BEN (ld_ben),
        .DRMUX  (drmux),
        .SR1MUX (sr1mux),
        .SR1Out (sr1_out),
        .SR2Out (sr2_out),
        .NZP    (nzp),
        .BEN    (ben)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q [$];
    string       tag_q [$];

    // Reference model
    logic [15:0] m_regs [8];
    logic [2:0]  m_nzp;
    logic        m_ben;
    logic        m_valid = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] observe(input string tag);
        case (tag)
            "sr1":   return sr1_out;
            "sr2":   return sr2_out;
            "nzp":   return {13'b0, nzp};
            "ben":   return {15'b0, ben};
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic push(input string tag, input logic [15:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_compare();
        string       tag;
        logic [15:0] v;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            tag = tag_q.pop_front();
            v   = exp_q.pop_front();
            check(tag, observe(tag), v);
        end
    endtask

    function automatic logic [15:0] mk_ir(input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
        return {4'h0, d, s1, 3'b000, s2};
    endfunction

    // One clock cycle: drive, predict, check reads before the edge, then
    // check NZP/BEN after the edge.
    task automatic step(input logic r, input logic lr, input logic lc, input logic lb,
                        input logic dm, input logic sm, input logic [15:0] i, input logic [15:0] b);
        logic [2:0]  dr, a1, a2, nn;
        logic [15:0] e1, e2;
        logic        nb;
        logic        pre_valid;

        @(negedge clk);
        rst = r; ld_reg = lr; ld_cc = lc; ld_ben = lb;
        drmux = dm; sr1mux = sm; ir = i; bus = b;

        dr = dm ? 3'd7 : i[11:9];
        a1 = sm ? i[8:6] : i[11:9];
        a2 = i[2:0];
        pre_valid = m_valid;

        if (pre_valid) begin
            e1 = m_regs[a1];
            e2 = m_regs[a2];
`ifdef REGFILE_BYPASS_EN
            if (lr && !r) begin
                if (a1 == dr) e1 = b;
                if (a2 == dr) e2 = b;
            end
`endif
            push("sr1", e1);
            push("sr2", e2);
        end

        // Next-state prediction
        if (r) begin
            nn = 3'b010;
            nb = 1'b0;
        end else begin
            nn = m_nzp;
            nb = m_ben;
            if (lb) nb = (i[11] & m_nzp[2]) | (i[10] & m_nzp[1]) | (i[9] & m_nzp[0]);
            if (lc) nn = b[15] ? 3'b100 : (b == 16'h0000) ? 3'b010 : 3'b001;
        end
        push("nzp", {13'b0, nn});
        push("ben", {15'b0, nb});

        #1;
        if (pre_valid) begin
            pop_compare();
            pop_compare();
        end

        if (r) begin
            for (int k = 0; k < 8; k++) m_regs[k] = 16'h0000;
            m_valid = 1'b1;
        end else if (lr) begin
            m_regs[dr] = b;
        end
        m_nzp = nn;
        m_ben = nb;

        @(posedge clk);
        #1;
        pop_compare();
        pop_compare();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; ld_reg = 1'b0; ld_cc = 1'b0; ld_ben = 1'b0;
        drmux = 1'b0; sr1mux = 1'b0; ir = 16'h0000; bus = 16'h0000;

        // Reset overrides all loads.
        step(1, 1, 1, 1, 0, 0, 16'h0E00, 16'hFFFF);
        step(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);

        // All registers read zero after reset, both SR1 selects.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] a;
            a = i[2:0];
            step(0, 0, 0, 0, 0, i[0], mk_ir(a, a, a), 16'h0000);
        end

        // Write R7 via IR[11:9] with DRMUX=0, read back through SR1MUX=0.
        step(0, 1, 0, 0, 0, 0, 16'h0E00, 16'hABCD);
        step(0, 0, 0, 0, 0, 0, 16'h0E00, 16'h0000);

        // Condition codes from negative, zero, positive.
        step(0, 0, 1, 0, 0, 0, 16'h0000, 16'h8000);
        step(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000);
        step(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0001);

        // BEN uses old NZP while NZP takes the new value.
        step(0, 0, 1, 0, 0, 0, 16'h0000, 16'h8000);
        step(0, 0, 1, 1, 0, 0, 16'h0800, 16'h0005);
        // NZP=001: mask 110 misses, mask 001 hits.
        step(0, 0, 0, 1, 0, 0, mk_ir(3'b110, 0, 0), 16'h0000);
        step(0, 0, 0, 1, 0, 0, mk_ir(3'b001, 0, 0), 16'h8000);

        // DRMUX=1 targets R7 regardless of IR[11:9]; R3 untouched.
        step(0, 1, 0, 0, 1, 0, mk_ir(3, 0, 0), 16'h1234);
        step(0, 0, 0, 0, 0, 1, mk_ir(3, 7, 3), 16'h0000);
        step(0, 1, 0, 0, 1, 0, mk_ir(7, 0, 0), 16'h5A5A);
        step(0, 0, 0, 0, 0, 0, mk_ir(7, 0, 7), 16'h0000);

        // Fill every register, then read via SR1MUX=1 and SR2.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] a;
            a = i[2:0];
            step(0, 1, 0, 0, 0, 0, mk_ir(a, 0, 0), {4'hC, 1'b0, a, 8'h3C} ^ 16'(i * 16'h0101));
        end
        for (int i = 0; i < 8; i++) begin
            logic [2:0] a;
            a = i[2:0];
            step(0, 0, 0, 0, 0, 1, mk_ir(0, a, ~a), 16'h0000);
        end

        // Same-cycle read of the register being written (bypass variant).
        step(0, 1, 0, 0, 0, 0, mk_ir(2, 0, 0), 16'h1111);
        step(0, 1, 0, 0, 0, 0, mk_ir(2, 5, 2), 16'h2222);
        step(0, 0, 0, 0, 0, 0, mk_ir(2, 0, 2), 16'h0000);

        // Hold with all loads low.
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, i[0], i[1], 16'($urandom), 16'($urandom));

        // Reset with a pending write: bypass suppressed, register cleared.
        step(1, 1, 1, 1, 0, 0, mk_ir(4, 4, 4), 16'hFFFF);
        // First edge after reset honours the loads.
        step(0, 1, 1, 1, 0, 0, mk_ir(4, 4, 4), 16'h8001);
        step(0, 0, 0, 0, 0, 0, mk_ir(4, 4, 4), 16'h0000);

        // Random mix of all controls, occasional reset.
        for (int i = 0; i < 80; i++) begin
            logic [15:0] rb;
            rb = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 16'($urandom), rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file_cc

// File: doc/reg_file_cc.md
REG_FILE_CC -- requirements
Module: reg_file_cc

Interface
REQ-001 Parameter DATA_W, default 16: register and bus width.
REQ-002 Parameter NREGS, default 8: number of general registers; register addresses are clog2(NREGS) = 3 bits.
REQ-003 Clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Bus  in  DATA_W  write-back data (ALU result or other datapath source).
REQ-006 IR  in  16  current instruction; supplies register fields and branch mask.
REQ-007 LD_REG  in  1  write Bus into the destination register at the next edge.
REQ-008 LD_CC  in  1  update the NZP register from Bus at the next edge.
REQ-009 LD_BEN  in  1  latch the branch-enable decision at the next edge.
REQ-010 DRMUX  in  1  destination select: 0 = IR[11:9]; 1 = R7.
REQ-011 SR1MUX  in  1  source-1 select: 0 = IR[11:9]; 1 = IR[8:6].
REQ-012 SR1Out  out  DATA_W  source-1 register value, feeds ALU A input.
REQ-013 SR2Out  out  DATA_W  register IR[2:0], feeds ALU B-select path.
REQ-014 NZP  out  3  condition codes {N,Z,P}.
REQ-015 BEN  out  1  latched branch enable.

Function
REQ-016 SR1Out and SR2Out SHALL be combinational reads of the register array, with zero-cycle latency from address change.
REQ-017 When LD_REG=1, Bus SHALL be written to R[DR] at the edge; the new value is visible on reads from the following cycle.
REQ-018 When LD_CC=1, NZP SHALL become 100 if Bus[15]=1, 010 if Bus=0, and 001 otherwise; exactly one bit is set after any load.
REQ-019 When LD_BEN=1, BEN SHALL become (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), computed from the NZP value held before the edge.
REQ-020 If LD_CC and LD_BEN are asserted in the same cycle, BEN SHALL use the old NZP and NZP SHALL take the new value.
REQ-021 LD_REG, LD_CC and LD_BEN SHALL be independent, and any combination may be asserted in one cycle.
REQ-022 With all load signals at 0, every register, NZP and BEN SHALL hold its value.
REQ-023 R7 SHALL be writable through both DRMUX settings, and DRMUX=1 with IR[11:9]=7 SHALL behave identically to DRMUX=0.

Reset
REQ-024 Reset=1 at an edge SHALL clear R0-R7 to 0, set NZP to 010 and clear BEN to 0, and it overrides all load signals in the same cycle.
REQ-025 The first edge with Reset=0 SHALL honour the load signals normally.

Configuration
REQ-026 With macro REGFILE_BYPASS_EN defined, when LD_REG=1 and a read address equals DR, that read port SHALL output Bus combinationally in the same cycle.
REQ-027 Without REGFILE_BYPASS_EN, reads SHALL return the pre-write register value until the edge.
REQ-028 With REGFILE_BYPASS_EN defined and Reset=1, bypass SHALL be suppressed and reads SHALL show the array contents.

Structure
REQ-029 A shared package SHALL hold DATA_W, the register-address width, the R7 index constant, the NZP reset constant 010 and an NZP bit-position typedef.
REQ-030 The condition-code and BEN logic SHALL be a sub-module named nzp_ben, instantiated once; the register array SHALL stay in the top level.

Verification
REQ-031 Reset, then read all registers -> all 0000, NZP=010, BEN=0.
REQ-032 IR=x"0E00" (DR=R7 field), DRMUX=0, LD_REG=1, Bus=x"ABCD" -> next cycle SR1Out=x"ABCD" with SR1MUX=0.
REQ-033 LD_CC with Bus=x"8000", then x"0000", then x"0001" -> NZP=100, then 010, then 001.
REQ-034 NZP=100, IR[11:9]=100, LD_CC=1 with Bus=x"0005", LD_BEN=1 in the same cycle -> BEN=1 and NZP=001.
REQ-035 Bypass: R2=x"1111", IR[2:0]=2, DR=2, LD_REG=1, Bus=x"2222" -> same-cycle SR2Out=x"2222" with REGFILE_BYPASS_EN defined, or x"1111" without it.
REQ-036 Reset=1 asserted together with LD_REG=1 and Bus=x"FFFF" -> target register reads 0000 after the edge.
